pc_fetch_reg: RTL and testbench

Program-counter register and instruction-fetch sequencer for the RISC32 core. It sits directly downstream of the PC-source multiplexer: it consumes the selected next PC and holds the architectural PC. It drives the instruction-memory request/response handshake and presents one fetched instruction at a time to decode. It supplies `pc_plus4` back to the multiplexer's sequential input and raises a sticky fault on a misaligned target.

---
 rtl/pc_fetch_reg_if.sv | 27 ++
 rtl/pc_fetch_reg.sv | 80 ++++++++
 tb/tb_pc_fetch_reg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_reg_if.sv
// Instruction-memory request/response bundle between the fetch sequencer and imem.
// Latency: none, plain wires; request side is valid/ready, response side is valid-only.
// Backpressure: imem_ready stalls the request; responses cannot be refused by the fetcher.
// Ports (master = fetcher): imem_req/imem_addr out, imem_ready/imem_rvalid/imem_rdata in.
interface pc_fetch_reg_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_reg.sv
// Architectural PC register and single-outstanding instruction-fetch sequencer.
// Latency: request accepted on edge 1, instruction valid after edge 2; 3 cycles/instr best case.
// Backpressure: holds request until imem_ready, waits forever for rvalid, stall holds the instr.
// Ports: clk, rst (async high); imem (master modport); next_pc/stall in;
//        pc, pc_plus4, inst, inst_valid, misalign, fault_pc out.
module pc_fetch_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_reg_if.master     imem,
  input  logic [31:0]        next_pc,
  input  logic               stall,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        inst,
  output logic               inst_valid,
  output logic               misalign,
  output logic [31:0]        fault_pc
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
      fault_pc   <= 32'h0;
    end else begin
      case (state)
        // Responses arriving here are leftovers from before a reset; drop them.
        S_REQ: begin
          if (imem.imem_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            inst       <= imem.imem_rdata;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end
        end
        // next_pc is only meaningful on the consume cycle.
        S_HOLD: begin
          if (!stall) begin
            pc         <= next_pc;
            inst       <= NOP_INST;
            inst_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              state <= S_REQ;
            end else begin
              state    <= S_FAULT;
              misalign <= 1'b1;
              fault_pc <= next_pc;
            end
          end
        end
        // Terminal until reset; pc stays at the faulting target.
        S_FAULT: state <= S_FAULT;
        default: state <= S_REQ;
      endcase
    end
  end

  // Gated by rst so no request leaks out while reset is held.
  assign imem.imem_req  = (state == S_REQ) && !rst;
  assign imem.imem_addr = pc;
  assign pc_plus4       = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_reg.sv
module tb_pc_fetch_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        stall;
  logic [31:0] pc, pc_plus4, inst, fault_pc;
  logic        inst_valid, misalign;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  pc_fetch_reg_if imem_bus ();

  pc_fetch_reg #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_bus),
    .next_pc    (next_pc),
    .stall      (stall),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst       (inst),
    .inst_valid (inst_valid),
    .misalign   (misalign),
    .fault_pc   (fault_pc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch at addr with bp cycles of imem_ready low, answer with word one cycle after accept.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int bp);
    for (int i = 0; i < bp; i++) begin
      check("bp_req", 32'(imem_bus.imem_req), 32'd1);
      check("bp_addr", imem_bus.imem_addr, addr);
      step();
    end
    check("req_hi", 32'(imem_bus.imem_req), 32'd1);
    check("req_addr", imem_bus.imem_addr, addr);
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready = 1'b0;
    check("wait_req", 32'(imem_bus.imem_req), 32'd0);
    check("wait_valid", 32'(inst_valid), 32'd0);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = word;
    exp_q.push_back(word);
    step();
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    check("hold_valid", 32'(inst_valid), 32'd1);
    if (inst_valid && exp_q.size() > 0) check("inst", inst, exp_q.pop_front());
  endtask

  task automatic consume(input logic [31:0] npc);
    next_pc = npc;
    stall   = 1'b0;
    step();
    check("consume_pc", pc, npc);
    check("consume_valid", 32'(inst_valid), 32'd0);
    check("consume_inst", inst, NOP);
  endtask

  initial begin
    rst = 1'b1;
    next_pc = 32'h0;
    stall = 1'b0;
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    step();
    step();
    check("rst_pc", pc, RST_PC);
    check("rst_pc4", pc_plus4, RST_PC + 32'd4);
    check("rst_inst", inst, NOP);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_req", 32'(imem_bus.imem_req), 32'd1);

    // reset fetch
    fetch(RST_PC, 32'hDEAD_BEEF, 0);
    check("fetch_pc4", pc_plus4, 32'h104);

    // stall in HOLD
    next_pc = 32'h104;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc", pc, RST_PC);
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_inst", inst, 32'hDEAD_BEEF);
    end
    consume(32'h104);
    check("seq_req", 32'(imem_bus.imem_req), 32'd1);
    check("seq_addr", imem_bus.imem_addr, 32'h104);

    // backpressure, with stall high through REQ/WAIT (must not matter)
    stall = 1'b1;
    fetch(32'h104, 32'h00A0_0093, 5);
    step();
    check("held_valid", 32'(inst_valid), 32'd1);
    check("held_inst", inst, 32'h00A0_0093);

    // wrap
    consume(32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    fetch(32'hFFFF_FFFC, 32'h1234_5678, 1);
    consume(32'h0);
    check("wrap_addr", imem_bus.imem_addr, 32'h0);

    // stale response after reset in WAIT
    imem_bus.imem_ready = 1'b1;
    step();
    imem_bus.imem_ready = 1'b0;
    check("stale_in_wait", 32'(imem_bus.imem_req), 32'd0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("stale_pc", pc, RST_PC);
    check("stale_req", 32'(imem_bus.imem_req), 32'd1);
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stale_valid", 32'(inst_valid), 32'd0);
      check("stale_inst", inst, NOP);
      check("stale_req_hold", 32'(imem_bus.imem_req), 32'd1);
      check("stale_addr", imem_bus.imem_addr, RST_PC);
    end
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    fetch(RST_PC, 32'h0000_0513, 0);

    // misaligned target
    consume(32'h0000_0206);
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_fault_pc", fault_pc, 32'h206);
    imem_bus.imem_ready  = 1'b1;
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      check("fault_req", 32'(imem_bus.imem_req), 32'd0);
      check("fault_valid", 32'(inst_valid), 32'd0);
      check("fault_pc_frozen", pc, 32'h206);
      step();
    end
    imem_bus.imem_ready  = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("clr_misalign", 32'(misalign), 32'd0);
    check("clr_fault_pc", fault_pc, 32'h0);
    check("clr_pc", pc, RST_PC);
    check("clr_req", 32'(imem_bus.imem_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
